// File: rtl/instr_buffer.sv
// instr_buffer -- fetch-to-decode instruction buffer.
//
// Small first-word-fall-through FIFO of {PC, instruction} pairs. Fetch pushes
// through a valid/ready handshake. Decode sees the head entry combinationally
// and pops it with out_ready. A flush (taken branch / redirect) discards every
// buffered entry, and it also drops any push offered in the same cycle.
//
// Optional feature: define IBUF_PREDECODE_EN to store a per-entry
// control-flow bit (JAL/JALR/BRANCH opcode) and present it on out_is_ctrl.
// Without the macro, out_is_ctrl is tied to 0 and no extra storage is built.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           discard all entries
//   in_valid/in_ready/in_pc/in_instr     fetch side handshake + payload
//   out_valid/out_ready/out_pc/out_instr decode side handshake + payload
//   out_is_ctrl                     head entry is a control-flow instruction
//   count                           number of valid entries
module instr_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_is_ctrl,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            push, pop;

    // Handshake flags come from registered count only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);

    // Flush swallows any push offered in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    // Payload storage needs no reset: the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_pc    = out_valid ? mem[rd_ptr].pc    : 32'h0;
    assign out_instr = out_valid ? mem[rd_ptr].instr : 32'h0;

`ifdef IBUF_PREDECODE_EN
    // Control-flow classification is done once at push time so decode sees
    // it straight out of a flop.
    logic [DEPTH-1:0] ctrl_mem;
    logic             ctrl_in;

    assign ctrl_in = (in_instr[6:0] == 7'b1101111) ||  // JAL
                     (in_instr[6:0] == 7'b1100111) ||  // JALR
                     (in_instr[6:0] == 7'b1100011);    // BRANCH

    always_ff @(posedge clk) begin
        if (push) ctrl_mem[wr_ptr] <= ctrl_in;
    end

    assign out_is_ctrl = out_valid && ctrl_mem[rd_ptr];
`else
    assign out_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, in_valid, out_ready;
    logic [31:0]   in_pc, in_instr;
    logic          in_ready, out_valid, out_is_ctrl;
    logic [31:0]   out_pc, out_instr;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: an ordered queue of buffered pairs.
    ent_t q[$];

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_is_ctrl(out_is_ctrl), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic is_ctrl(input logic [31:0] instr);
`ifdef IBUF_PREDECODE_EN
        return instr[6:0] == 7'h6F || instr[6:0] == 7'h67 || instr[6:0] == 7'h63;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_pc();
        return (q.size() != 0) ? q[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q.size() != 0) ? q[0].instr : 32'h0;
    endfunction

    function automatic logic exp_ctrl();
        return (q.size() != 0) ? is_ctrl(q[0].instr) : 1'b0;
    endfunction

    // Drive one clock cycle, advance the model, and return at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        logic do_push, do_pop;
        in_valid = v; in_pc = pc; in_instr = instr; out_ready = rdy; flush = fl;
        do_push = v && (q.size() != DEPTH);
        do_pop  = rdy && (q.size() != 0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{pc: pc, instr: instr});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        checks++; if (count !== '0)       begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_pc !== 32'h0)   begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        checks++; if (out_is_ctrl !== 1'b0) begin errors++; $display("FAIL reset_out_is_ctrl: got %b want 0", out_is_ctrl); end
    endtask

    task automatic test_single();
        cycle(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h0)          begin errors++; $display("FAIL single_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h00000013) begin errors++; $display("FAIL single_instr: got %h want 00000013", out_instr); end
        checks++; if (count !== CW'(1))          begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== '0)       begin errors++; $display("FAIL single_pop_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        // in_ready must not react to out_ready within the cycle.
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_indep: got %b want 0", in_ready); end
        out_ready = 1'b0;
        cycle(1'b1, 32'h10, 32'h00000013, 1'b0, 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_reject_count: got %0d want %0d", count, DEPTH); end
        // Pop while offering 0x10: refused while full, accepted one cycle later.
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL fill_drain_%0d: got valid=%b pc=%h want valid=1 pc=%h", i, out_valid, out_pc, 32'(4 * i));
            end
            cycle(i < 2, 32'h10, 32'h00000013, 1'b1, 1'b0);
        end
        checks++; if (count !== '0) begin errors++; $display("FAIL fill_drain_empty: got %0d want 0", count); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b1, 1'b0);
            checks++;
            if (count !== CW'(1) || out_pc !== 32'h200 + 32'(4 * i)) begin
                errors++; $display("FAIL stream_%0d: got count=%0d pc=%h want count=1 pc=%h", i, count, out_pc, 32'h200 + 32'(4 * i));
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        cycle(1'b1, 32'h18, 32'h00000013, 1'b1, 1'b1);
        checks++; if (count !== '0)       begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        cycle(1'b1, 32'h20, 32'h00000013, 1'b0, 1'b0);
        checks++;
        if (out_pc !== 32'h20 || count !== CW'(1)) begin
            errors++; $display("FAIL flush_target: got pc=%h count=%0d want pc=00000020 count=1", out_pc, count);
        end
        drain();
    endtask

    task automatic test_predecode();
        logic [31:0] instrs [5];
        logic        want   [5];
        instrs = '{32'h0080006F, 32'h00000013, 32'h000080E7, 32'h00208463, 32'h00000033};
`ifdef IBUF_PREDECODE_EN
        want = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h400 + 32'(4 * i), instrs[i], 1'b0, 1'b0);
            checks++;
            if (out_is_ctrl !== want[i]) begin
                errors++; $display("FAIL predecode_%0d: instr=%h got %b want %b", i, instrs[i], out_is_ctrl, want[i]);
            end
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h500, 32'h0080006F, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 32'h00000013, 1'b0, 1'b0);
        rst_n = 1'b0; #1;
        q.delete();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got count=%0d valid=%b ready=%b pc=%h want 0/0/1/0", count, out_valid, in_ready, out_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] pc_ctr = 32'h1000;
        logic [31:0] ins;
        logic [6:0]  ops [4];
        ops = '{7'h6F, 7'h67, 7'h63, 7'h13};
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[6:0] = ops[$urandom_range(0, 3)];
            cycle($urandom_range(0, 3) != 0, pc_ctr, ins,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            pc_ctr = pc_ctr + 32'd4;
            checks++; if (count !== CW'(q.size()))         begin errors++; $display("FAIL rand_count @%0d: got %0d want %0d", i, count, q.size()); end
            checks++; if (out_valid !== (q.size() != 0))   begin errors++; $display("FAIL rand_valid @%0d: got %b want %b", i, out_valid, q.size() != 0); end
            checks++; if (in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rand_ready @%0d: got %b want %b", i, in_ready, q.size() != DEPTH); end
            checks++; if (out_pc !== exp_pc())             begin errors++; $display("FAIL rand_pc @%0d: got %h want %h", i, out_pc, exp_pc()); end
            checks++; if (out_instr !== exp_instr())       begin errors++; $display("FAIL rand_instr @%0d: got %h want %h", i, out_instr, exp_instr()); end
            checks++; if (out_is_ctrl !== exp_ctrl())      begin errors++; $display("FAIL rand_ctrl @%0d: got %b want %b", i, out_is_ctrl, exp_ctrl()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_predecode();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Instruction buffer between the fetch stage and decode. It accepts {PC, instruction} pairs from the fetch/instruction-memory path through a valid/ready handshake and holds them in a small first-word-fall-through FIFO. It presents them in order to decode. A flush, driven by a taken branch or redirect, discards every buffered entry so that no wrong-path instruction reaches decode.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard all entries (asserted together with fetch's branch_taken)
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  buffer can accept a pair this cycle
- in_pc  input  32  PC of the incoming instruction (fetch pc_out)
- in_instr  input  32  instruction word fetched at in_pc
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes the head entry this cycle
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction word of the head entry
- out_is_ctrl  output  1  head entry is a control-flow instruction (see Configuration)
- count  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage is a circular array of DEPTH entries with read pointer rd_ptr, write pointer wr_ptr ($clog2(DEPTH) bits each, natural wrap) and occupancy register count.
- A push happens when in_valid && in_ready. The pair is written at wr_ptr, then wr_ptr increments.
- A pop happens when out_valid && out_ready. rd_ptr increments.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
- When full, in_ready is 0, so a pop and a push never share a full-cycle. The slot freed by the pop becomes available the next cycle.
- out_valid = (count != 0).
- out_pc and out_instr come combinationally from the entry at rd_ptr (FWFT). They read 0 when out_valid is 0.
- Flush has priority over push and pop.
  - In a flush cycle, count, rd_ptr and wr_ptr all go to 0.
  - A push presented in that cycle is dropped.
  - A pop presented in that cycle is irrelevant.
- Entries stay in order. Each PC/instruction pair is delivered exactly once, unless flushed.
- Reset mid-operation: all entries are discarded immediately, with the same end state as flush.

## Timing
- Reset values: count=0, out_valid=0, out_pc=0, out_instr=0, out_is_ctrl=0, in_ready=1. Pointers are 0.
- Latency: a pair pushed into an empty buffer in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: one push and one pop per cycle in steady state (0 < count < DEPTH).
- Flush asserted in cycle N gives out_valid=0 and count=0 in cycle N+1. The first post-flush push (the branch target) can occur in cycle N+1.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Configuration
- IBUF_PREDECODE_EN, when defined:
  - Each entry stores one extra bit, computed at push time from in_instr[6:0].
  - The bit is 1 for opcode 7'b1101111 (JAL), 7'b1100111 (JALR) or 7'b1100011 (BRANCH).
  - out_is_ctrl presents this bit for the head entry. It is 0 when out_valid is 0.
- When not defined:
  - No extra storage is built.
  - out_is_ctrl is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset then idle: rst_n low, then released -> count=0, out_valid=0, in_ready=1, out_pc=0.
- Single pass-through: push pc=0x0, instr=0x00000013 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00000013, count=1. Then out_ready=1 for one cycle -> count=0, out_valid=0.
- Fill and backpressure (DEPTH=4): push pc 0x0, 0x4, 0x8, 0xC with out_ready=0 -> count=4, in_ready=0. A fifth push of pc 0x10 is not accepted. Draining yields 0x0, 0x4, 0x8, 0xC in order, then 0x10 once accepted.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles, with pc incrementing by 4 -> count stays 1, and out_pc follows in_pc one cycle later with no gaps.
- Flush: with 3 entries buffered, assert flush while pushing pc=0x18 -> next cycle count=0, out_valid=0, and 0x18 is never delivered. Then push pc=0x20 -> out_pc=0x20 one cycle later.
- Predecode (IBUF_PREDECODE_EN defined):
  - Push instr=0x0080006F (JAL) -> out_is_ctrl=1.
  - Push instr=0x00000013 -> out_is_ctrl=0.
  - Without the macro, out_is_ctrl=0 for both.
